// File: rtl/mem_stage_pkg.sv
// Shared CPU definitions for the memory stage: FSM states, writeback source codes and timeout.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } mem_state_t;

    localparam logic [1:0] DST_ALU  = 2'b00;
    localparam logic [1:0] DST_MEM  = 2'b01;
    localparam logic [1:0] DST_LINK = 2'b10;

    localparam logic [7:0] TIMEOUT = 8'd255;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for the memory stage; flags expiry when the count reaches TIMEOUT.
module mem_timeout_ctr
    import mem_stage_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 8'd0;
        end else if (clear) begin
            count_reg <= 8'd0;
        end else if (enable) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    assign expired = (count_reg == TIMEOUT);

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues one data-memory access per load/store, stalls upstream
// until ack or timeout, and produces a single-cycle writeback strobe per instruction.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pcIn,
    input  logic [31:0] src1RegIn,
    input  logic [31:0] aluCalcIn,
    input  logic [3:0]  destRegIn,
    input  logic        regWrEnIn,
    input  logic        memWrEnIn,
    input  logic        isLWIn,
    input  logic [1:0]  dstMuxIn,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic [31:0] dmemAddr,
    output logic [31:0] dmemWData,
    input  logic        dmemAck,
    input  logic [31:0] dmemRData,
    output logic        stall,
    output logic        wbRegWrEn,
    output logic [3:0]  wbDestReg,
    output logic [31:0] wbData,
    output logic        memErr
);

    // Reset asserts immediately but releases two edges later, so the first active edge sees IDLE.
    logic [1:0] rst_sync_reg;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_reg[1];

    mem_state_t  state_reg, state_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [3:0]  lat_dest_reg, lat_dest_next;
    logic        lat_we_reg, lat_we_next;
    logic        wb_we_reg, wb_we_next;
    logic [3:0]  wb_dest_reg, wb_dest_next;
    logic [31:0] wb_data_reg, wb_data_next;
    logic        mem_err_reg, mem_err_next;

    logic        mem_op, is_store, is_load;
    logic [31:0] wb_src;
    logic        stall_raw, req_raw, we_raw;
    logic        ctr_clear, ctr_en, ctr_expired;

    // A load with the store bit also set is handled as a plain store.
    assign mem_op   = isLWIn | memWrEnIn;
    assign is_store = memWrEnIn;
    assign is_load  = isLWIn & ~memWrEnIn;

    always_comb begin
        case (dstMuxIn)
            DST_LINK:         wb_src = pcIn + 32'd4;
            DST_ALU, DST_MEM: wb_src = aluCalcIn;
            default:          wb_src = aluCalcIn;
        endcase
    end

    mem_timeout_ctr u_timeout_ctr (
        .clk     (clk),
        .rst_n   (rst_int_n),
        .clear   (ctr_clear),
        .enable  (ctr_en),
        .expired (ctr_expired)
    );

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (mem_op) begin
                    state_next = is_store ? WR_WAIT : RD_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (dmemAck || ctr_expired) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_raw       = 1'b0;
        we_raw        = 1'b0;
        stall_raw     = 1'b0;
        ctr_clear     = 1'b0;
        ctr_en        = 1'b0;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        lat_dest_next = lat_dest_reg;
        lat_we_next   = lat_we_reg;
        wb_we_next    = 1'b0;
        wb_dest_next  = wb_dest_reg;
        wb_data_next  = wb_data_reg;
        mem_err_next  = mem_err_reg;
        case (state_reg)
            IDLE: begin
                ctr_clear = 1'b1;
                if (mem_op) begin
                    stall_raw     = 1'b1;
                    addr_next     = word_align(aluCalcIn);
                    wdata_next    = src1RegIn;
                    lat_dest_next = destRegIn;
                    lat_we_next   = regWrEnIn & is_load;
                end else begin
                    wb_we_next   = regWrEnIn;
                    wb_dest_next = destRegIn;
                    wb_data_next = wb_src;
                end
            end
            RD_WAIT, WR_WAIT: begin
                req_raw = 1'b1;
                we_raw  = (state_reg == WR_WAIT);
                // Ack beats a simultaneous timeout so a late-but-valid completion is kept.
                if (dmemAck) begin
                    if (state_reg == RD_WAIT) begin
                        wb_we_next   = lat_we_reg;
                        wb_dest_next = lat_dest_reg;
                        wb_data_next = dmemRData;
                    end
                end else if (ctr_expired) begin
                    mem_err_next = 1'b1;
                end else begin
                    stall_raw = 1'b1;
                    ctr_en    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            addr_reg     <= 32'd0;
            wdata_reg    <= 32'd0;
            lat_dest_reg <= 4'd0;
            lat_we_reg   <= 1'b0;
            wb_we_reg    <= 1'b0;
            wb_dest_reg  <= 4'd0;
            wb_data_reg  <= 32'd0;
            mem_err_reg  <= 1'b0;
        end else begin
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            lat_dest_reg <= lat_dest_next;
            lat_we_reg   <= lat_we_next;
            wb_we_reg    <= wb_we_next;
            wb_dest_reg  <= wb_dest_next;
            wb_data_reg  <= wb_data_next;
            mem_err_reg  <= mem_err_next;
        end
    end

    assign dmemReq   = req_raw;
    assign dmemWe    = we_raw;
    assign dmemAddr  = addr_reg;
    assign dmemWData = wdata_reg;
    assign stall     = stall_raw & rst_int_n;
    assign wbRegWrEn = wb_we_reg;
    assign wbDestReg = wb_dest_reg;
    assign wbData    = wb_data_reg;
    assign memErr    = mem_err_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected writebacks, a monitor checks them.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] pcIn = '0, src1RegIn = '0, aluCalcIn = '0;
    logic [3:0]  destRegIn = '0;
    logic        regWrEnIn = 1'b0, memWrEnIn = 1'b0, isLWIn = 1'b0;
    logic [1:0]  dstMuxIn = '0;
    logic        dmemReq, dmemWe;
    logic [31:0] dmemAddr, dmemWData;
    logic        dmemAck = 1'b0;
    logic [31:0] dmemRData = '0;
    logic        stall, wbRegWrEn;
    logic [3:0]  wbDestReg;
    logic [31:0] wbData;
    logic        memErr;

    typedef struct packed {
        logic [3:0]  dest;
        logic [31:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  compared = 0;
    int  mismatched = 0;
    int  wb_seen = 0;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n), .pcIn(pcIn), .src1RegIn(src1RegIn),
        .aluCalcIn(aluCalcIn), .destRegIn(destRegIn), .regWrEnIn(regWrEnIn),
        .memWrEnIn(memWrEnIn), .isLWIn(isLWIn), .dstMuxIn(dstMuxIn),
        .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr),
        .dmemWData(dmemWData), .dmemAck(dmemAck), .dmemRData(dmemRData),
        .stall(stall), .wbRegWrEn(wbRegWrEn), .wbDestReg(wbDestReg),
        .wbData(wbData), .memErr(memErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: every writeback strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (wbRegWrEn === 1'b1) begin
            compared++;
            wb_seen++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_wb: got dest=%0d data=%h required no writeback",
                         wbDestReg, wbData);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                if (wbDestReg !== e.dest || wbData !== e.data) begin
                    mismatched++;
                    $display("FAIL wb_value: got dest=%0d data=%h required dest=%0d data=%h",
                             wbDestReg, wbData, e.dest, e.data);
                end else begin
                    $display("wb %0d: dest=%0d data=%h", wb_seen, wbDestReg, wbData);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        isLWIn = 1'b0; memWrEnIn = 1'b0; regWrEnIn = 1'b0;
        dstMuxIn = 2'b00; destRegIn = 4'd0;
    endtask

    task automatic issue_alu(input logic [31:0] pc, input logic [31:0] alu, input logic [1:0] mux,
                             input logic we, input logic [3:0] dest, input logic [31:0] exp_data);
        pcIn = pc; aluCalcIn = alu; dstMuxIn = mux; regWrEnIn = we; destRegIn = dest;
        isLWIn = 1'b0; memWrEnIn = 1'b0;
        if (we) exp_q.push_back('{dest: dest, data: exp_data});
        @(negedge clk);
        check("alu_stall", {31'd0, stall}, 32'd0);
        step();
    endtask

    // ack_wait = cycles after the issue edge before the ack cycle (ack lands on WAIT cycle ack_wait).
    task automatic do_mem(input logic lw, input logic sw, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input logic [3:0] dest,
                          input int ack_wait, input logic [31:0] exp_addr, input logic exp_we);
        isLWIn = lw; memWrEnIn = sw; aluCalcIn = addr; src1RegIn = wdata;
        destRegIn = dest; regWrEnIn = 1'b1; dstMuxIn = 2'b01;
        @(negedge clk);
        check("issue_stall", {31'd0, stall}, 32'd1);
        check("issue_req", {31'd0, dmemReq}, 32'd0);
        step();
        bubble();
        for (int i = 1; i < ack_wait; i++) begin
            @(negedge clk);
            check("wait_stall", {31'd0, stall}, 32'd1);
            check("wait_req", {31'd0, dmemReq}, 32'd1);
            check("wait_addr", dmemAddr, exp_addr);
            step();
        end
        dmemAck = 1'b1; dmemRData = rdata;
        if (lw && !sw) exp_q.push_back('{dest: dest, data: rdata});
        @(negedge clk);
        check("ack_stall", {31'd0, stall}, 32'd0);
        check("ack_req", {31'd0, dmemReq}, 32'd1);
        check("ack_we", {31'd0, dmemWe}, {31'd0, exp_we});
        check("ack_addr", dmemAddr, exp_addr);
        if (exp_we) check("ack_wdata", dmemWData, wdata);
        step();
        dmemAck = 1'b0; dmemRData = 32'd0;
        @(negedge clk);
        check("post_req", {31'd0, dmemReq}, 32'd0);
        step();
    endtask

    initial begin
        int stall_cycles;
        #1 rst_n = 1'b0;
        isLWIn = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_req", {31'd0, dmemReq}, 32'd0);
        check("rst_addr", dmemAddr, 32'd0);
        check("rst_wdata", dmemWData, 32'd0);
        check("rst_wb", {31'd0, wbRegWrEn}, 32'd0);
        check("rst_wbdata", wbData, 32'd0);
        check("rst_wbdest", {28'd0, wbDestReg}, 32'd0);
        check("rst_memerr", {31'd0, memErr}, 32'd0);
        bubble();
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        issue_alu(32'h0, 32'h0000_1234, 2'b00, 1'b1, 4'd5, 32'h0000_1234);
        issue_alu(32'hFFFF_FFFC, 32'h0, 2'b10, 1'b1, 4'd14, 32'h0000_0000);
        issue_alu(32'h0, 32'h0000_0055, 2'b11, 1'b1, 4'd3, 32'h0000_0055);
        issue_alu(32'h0000_1000, 32'h0, 2'b10, 1'b1, 4'd1, 32'h0000_1004);
        issue_alu(32'h0, 32'hDEAD_0000, 2'b00, 1'b0, 4'd6, 32'h0);
        bubble();
        step();

        do_mem(1'b1, 1'b0, 32'h0000_0103, 32'h0, 32'hCAFE_F00D, 4'd7, 3, 32'h0000_0100, 1'b0);

        dmemAck = 1'b1; dmemRData = 32'h1111_1111;
        @(negedge clk);
        check("idle_ack_req", {31'd0, dmemReq}, 32'd0);
        check("idle_ack_stall", {31'd0, stall}, 32'd0);
        step();
        dmemAck = 1'b0;
        @(negedge clk);
        check("idle_addr_hold", dmemAddr, 32'h0000_0100);
        step();

        do_mem(1'b0, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 32'h0, 4'd9, 1, 32'h0000_0040, 1'b1);
        do_mem(1'b1, 1'b1, 32'h0000_0086, 32'h1111_2222, 32'h0, 4'd4, 2, 32'h0000_0084, 1'b1);
        do_mem(1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'h600D_D00D, 4'd2, 256, 32'h0000_0300, 1'b0);
        check("ack_at_timeout_memerr", {31'd0, memErr}, 32'd0);

        // Load that never completes.
        isLWIn = 1'b1; aluCalcIn = 32'h0000_0200; destRegIn = 4'd8; regWrEnIn = 1'b1;
        @(negedge clk);
        stall_cycles = (stall === 1'b1) ? 1 : 0;
        step();
        bubble();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (stall !== 1'b1) break;
            stall_cycles++;
            step();
        end
        check("timeout_stall_cycles", stall_cycles, 32'd256);
        check("timeout_req_last", {31'd0, dmemReq}, 32'd1);
        check("timeout_memerr_pre", {31'd0, memErr}, 32'd0);
        step();
        @(negedge clk);
        check("timeout_memerr", {31'd0, memErr}, 32'd1);
        check("timeout_req_idle", {31'd0, dmemReq}, 32'd0);
        step();
        dmemAck = 1'b1; dmemRData = 32'hBAD0_BAD0;
        step();
        dmemAck = 1'b0;
        step();
        issue_alu(32'h0, 32'h0000_0777, 2'b00, 1'b1, 4'd11, 32'h0000_0777);
        bubble();
        @(negedge clk);
        check("memerr_sticky", {31'd0, memErr}, 32'd1);
        step();

        // Reset during the second RD_WAIT cycle.
        isLWIn = 1'b1; aluCalcIn = 32'h0000_0500; destRegIn = 4'd12; regWrEnIn = 1'b1;
        step();
        bubble();
        @(negedge clk);
        check("mid_req_c1", {31'd0, dmemReq}, 32'd1);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, dmemReq}, 32'd0);
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        check("mid_rst_memerr", {31'd0, memErr}, 32'd0);
        check("mid_rst_addr", dmemAddr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        dmemAck = 1'b1; dmemRData = 32'h5555_AAAA;
        step();
        dmemAck = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("post_rst_memerr", {31'd0, memErr}, 32'd0);
        check("post_rst_req", {31'd0, dmemReq}, 32'd0);
        step();

        issue_alu(32'h0, 32'h0000_ABCD, 2'b00, 1'b1, 4'd15, 32'h0000_ABCD);
        bubble();
        repeat (3) step();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 required finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  pcIn  in  32  PC of instruction held in execute buffer
  src1RegIn  in  32  store data
  aluCalcIn  in  32  ALU result / byte address
  destRegIn  in  4  destination register
  regWrEnIn  in  1  instruction writes a register
  memWrEnIn  in  1  instruction is a store
  isLWIn  in  1  instruction is a load
  dstMuxIn  in  2  writeback source select
  dmemReq  out  1  memory request, held until ack
  dmemWe  out  1  request is a write
  dmemAddr  out  32  word-aligned byte address
  dmemWData  out  32  store data
  dmemAck  in  1  memory completion, one-cycle pulse
  dmemRData  in  32  load data, valid with dmemAck
  stall  out  1  freeze upstream pipeline
  wbRegWrEn  out  1  writeback strobe, one cycle per instruction
  wbDestReg  out  4  writeback register
  wbData  out  32  writeback value
  memErr  out  1  sticky memory timeout flag
REQ-003 Constants: TIMEOUT = 255 cycles; DST_ALU = 2'b00, DST_MEM = 2'b01, DST_LINK = 2'b10; 2'b11 SHALL decode as DST_ALU.

Function
REQ-004 Memory op = isLWIn | memWrEnIn; isLWIn and memWrEnIn both set SHALL be treated as store with no register write.
REQ-005 FSM states SHALL be IDLE, RD_WAIT, WR_WAIT.
REQ-006 IDLE, non-memory op: at next edge wbRegWrEn <= regWrEnIn, wbDestReg <= destRegIn, wbData <= selected source; latency 1, stall = 0.
REQ-007 Sources: DST_ALU = aluCalcIn; DST_LINK = pcIn + 4 (modulo 2^32); DST_MEM valid only for loads.
REQ-008 IDLE, memory op: stall SHALL be 1 combinationally that cycle; at next edge latch destRegIn, regWrEnIn, store data, address {aluCalcIn[31:2],2'b00}; go RD_WAIT (load) or WR_WAIT (store); wbRegWrEn <= 0.
REQ-009 In RD_WAIT/WR_WAIT: dmemReq = 1, dmemWe = 1 only in WR_WAIT, dmemAddr/dmemWData from latched values, stable until ack.
REQ-010 stall SHALL stay 1 every WAIT cycle without dmemAck and SHALL be 0 in the cycle dmemAck = 1, so upstream advances on that edge.
REQ-011 On dmemAck in RD_WAIT: next edge wbData <= dmemRData, wbRegWrEn <= latched regWrEn, wbDestReg <= latched dest; go IDLE.
REQ-012 On dmemAck in WR_WAIT: next edge wbRegWrEn <= 0; go IDLE.
REQ-013 wbRegWrEn SHALL be 0 in every cycle not completing an instruction (bubble).
REQ-014 Wait counter (8 bit) SHALL clear on WAIT entry, increment each WAIT cycle without ack; at count TIMEOUT: go IDLE, memErr <= 1, stall = 0 that cycle, wbRegWrEn <= 0 (load result dropped).
REQ-015 memErr SHALL be sticky; cleared only by reset.
REQ-016 dmemAck in IDLE SHALL be ignored with no state or output change.
REQ-017 dmemAck in the same cycle the counter reaches TIMEOUT SHALL win: normal completion, memErr unchanged.
REQ-018 dmemReq, dmemWe SHALL be 0 in IDLE; dmemAddr/dmemWData hold last values.

Reset
REQ-019 rst_n low SHALL immediately force state IDLE, counter 0, and all outputs 0 (dmemReq, dmemWe, dmemAddr, dmemWData, stall, wbRegWrEn, wbDestReg, wbData, memErr).
REQ-020 Reset mid-transaction SHALL abandon the access; no writeback, no memErr.
REQ-021 Reset release SHALL be synchronized so the first active edge sees IDLE.

Structure
REQ-022 FSM state type, DST_* encodings and TIMEOUT SHALL live in the shared CPU package.
REQ-023 Wait counter with timeout compare SHALL be sub-module mem_timeout_ctr (clear, enable, expired).

Verification
REQ-024 ALU op: aluCalcIn=0x1234, dstMux=00, regWrEn=1, dest=5 -> next cycle wbRegWrEn=1, wbDestReg=5, wbData=0x1234, stall never 1.
REQ-025 Link op: pcIn=0xFFFFFFFC, dstMux=10 -> wbData=0x00000000.
REQ-026 Load addr 0x103, ack after 3 cycles with rdata 0xCAFEF00D -> dmemAddr=0x100, stall 1 for 3 cycles, then wbData=0xCAFEF00D, wbRegWrEn=1 one cycle.
REQ-027 Store addr 0x40, data 0xA5A5A5A5, ack after 1 cycle -> dmemWe=1, dmemWData=0xA5A5A5A5, wbRegWrEn stays 0.
REQ-028 Load with no ack -> after 255 WAIT cycles memErr=1, stall=0, no writeback; later ack ignored; memErr held until rst_n.
REQ-029 rst_n asserted in RD_WAIT cycle 2 -> dmemReq=0 immediately, no writeback after release.
